// File: rtl/axil_regbank_pkg.sv
// axil_regbank_pkg: shared definitions for the AXI4-Lite register bank.
//   resp_t            2-bit AXI response code
//   RESP_*            response encodings used on the B and R channels
//   index_width()     number of register-index bits in a byte address
package axil_regbank_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  // Register index = byte address with the in-word byte offset stripped off.
  function automatic int index_width(input int addr_w, input int data_w);
    return addr_w - $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/axil_regbank_wr.sv
// axil_regbank_wr: AXI4-Lite write front end.
// Holds AW and W independently, joins them, emits a one-cycle commit strobe
// and runs the B channel.
//   clk, rst_n                  clock, synchronous active-low reset
//   awaddr/awvalid/awready      write address channel
//   wdata/wstrb/wvalid/wready   write data channel
//   bresp/bvalid/bready         write response channel
//   commit                      high on the edge that completes a write
//   commit_addr/data/strb       the joined write, valid while commit is high
//   commit_resp                 response decided by the register decoder
module axil_regbank_wr
  import axil_regbank_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output resp_t                 bresp,
  output logic                  bvalid,
  input  logic                  bready,
  output logic                  commit,
  output logic [ADDR_W-1:0]     commit_addr,
  output logic [DATA_W-1:0]     commit_data,
  output logic [DATA_W/8-1:0]   commit_strb,
  input  resp_t                 commit_resp
);

  logic                  active_reg;
  logic                  aw_full_reg;
  logic                  w_full_reg;
  logic [ADDR_W-1:0]     aw_addr_reg;
  logic [DATA_W-1:0]     w_data_reg;
  logic [DATA_W/8-1:0]   w_strb_reg;
  logic                  bvalid_reg;
  resp_t                 bresp_reg;
  logic                  aw_hs;
  logic                  w_hs;

  // Readies depend only on registered state; active_reg keeps them low
  // until the first edge that samples reset released.
  assign awready = active_reg && !aw_full_reg && !bvalid_reg;
  assign wready  = active_reg && !w_full_reg  && !bvalid_reg;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;

  // A half arriving this cycle bypasses its holder so the commit lands on the
  // edge of the later handshake.
  assign commit      = (aw_full_reg || aw_hs) && (w_full_reg || w_hs);
  assign commit_addr = aw_full_reg ? aw_addr_reg : awaddr;
  assign commit_data = w_full_reg  ? w_data_reg  : wdata;
  assign commit_strb = w_full_reg  ? w_strb_reg  : wstrb;

  assign bvalid = bvalid_reg;
  assign bresp  = bresp_reg;

  // commit and a pending B are mutually exclusive: the readies are held low
  // while bvalid is set, so no holder can fill.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_reg  <= 1'b0;
      aw_full_reg <= 1'b0;
      w_full_reg  <= 1'b0;
      aw_addr_reg <= '0;
      w_data_reg  <= '0;
      w_strb_reg  <= '0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= RESP_OKAY;
    end else begin
      active_reg <= 1'b1;
      if (commit) begin
        aw_full_reg <= 1'b0;
        w_full_reg  <= 1'b0;
        bvalid_reg  <= 1'b1;
        bresp_reg   <= commit_resp;
      end else begin
        if (aw_hs) begin
          aw_full_reg <= 1'b1;
          aw_addr_reg <= awaddr;
        end
        if (w_hs) begin
          w_full_reg <= 1'b1;
          w_data_reg <= wdata;
          w_strb_reg <= wstrb;
        end
        if (bvalid_reg && bready) begin
          bvalid_reg <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/axil_regbank.sv
// axil_regbank: parametrised AXI4-Lite slave register bank.
//   s00_axi_aclk, s00_axi_aresetn   clock, synchronous active-low reset
//   s00_axi_aw*/w*/b*               write address / data / response channels
//   s00_axi_ar*/r*                  read address / data channels
//   reg_q      flattened read-write register contents (read-only slots are 0)
//   wr_pulse   one-cycle strobe per successful write to register i
//   hw_status  values returned for read-only registers
module axil_regbank
  import axil_regbank_pkg::*;
#(
  parameter int                   C_S_AXI_DATA_WIDTH = 32,
  parameter int                   C_S_AXI_ADDR_WIDTH = 5,
  parameter int                   NUM_REGS           = 8,
  parameter logic [NUM_REGS-1:0]  RO_MASK            = 8'hF0
) (
  input  logic                                   s00_axi_aclk,
  input  logic                                   s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s00_axi_awaddr,
  input  logic [2:0]                             s00_axi_awprot,
  input  logic                                   s00_axi_awvalid,
  output logic                                   s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        s00_axi_wstrb,
  input  logic                                   s00_axi_wvalid,
  output logic                                   s00_axi_wready,
  output logic [1:0]                             s00_axi_bresp,
  output logic                                   s00_axi_bvalid,
  input  logic                                   s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s00_axi_araddr,
  input  logic [2:0]                             s00_axi_arprot,
  input  logic                                   s00_axi_arvalid,
  output logic                                   s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          s00_axi_rdata,
  output logic [1:0]                             s00_axi_rresp,
  output logic                                   s00_axi_rvalid,
  input  logic                                   s00_axi_rready,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]                    wr_pulse,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] hw_status
);

  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int AW    = C_S_AXI_ADDR_WIDTH;
  localparam int SW    = DW / 8;
  localparam int LSB   = $clog2(SW);
  localparam int IDX_W = index_width(AW, DW);

  logic                 clk;
  logic                 commit;
  logic [AW-1:0]        commit_addr;
  logic [DW-1:0]        commit_data;
  logic [SW-1:0]        commit_strb;
  resp_t                commit_resp;
  resp_t                bresp;
  logic [IDX_W-1:0]     wr_idx;
  logic [NUM_REGS-1:0]  wr_hit;
  logic                 wr_in_range;
  logic                 wr_ro;
  logic                 wr_en;
  logic [NUM_REGS-1:0]  wr_pulse_reg;
  logic [DW-1:0]        reg_value [NUM_REGS];

  logic [IDX_W-1:0]     rd_idx;
  logic                 rd_in_range;
  logic [DW-1:0]        rd_value;
  logic                 rd_active_reg;
  logic                 rvalid_reg;
  logic [DW-1:0]        rdata_reg;
  resp_t                rresp_reg;
  logic                 ar_hs;
  logic                 unused;

  assign clk = s00_axi_aclk;

  axil_regbank_wr #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) u_wr (
    .clk         (clk),
    .rst_n       (s00_axi_aresetn),
    .awaddr      (s00_axi_awaddr),
    .awvalid     (s00_axi_awvalid),
    .awready     (s00_axi_awready),
    .wdata       (s00_axi_wdata),
    .wstrb       (s00_axi_wstrb),
    .wvalid      (s00_axi_wvalid),
    .wready      (s00_axi_wready),
    .bresp       (bresp),
    .bvalid      (s00_axi_bvalid),
    .bready      (s00_axi_bready),
    .commit      (commit),
    .commit_addr (commit_addr),
    .commit_data (commit_data),
    .commit_strb (commit_strb),
    .commit_resp (commit_resp)
  );

  assign s00_axi_bresp = bresp;

  // Write decode: one-hot hit vector; an index past NUM_REGS hits nothing.
  assign wr_idx = commit_addr[AW-1:LSB];

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_hit
    assign wr_hit[gi] = (wr_idx == IDX_W'(gi));
  end

  assign wr_in_range = |wr_hit;
  assign wr_ro       = |(wr_hit & RO_MASK);
  assign commit_resp = !wr_in_range ? RESP_DECERR :
                       wr_ro        ? RESP_SLVERR : RESP_OKAY;
  assign wr_en       = commit && wr_in_range && !wr_ro;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    if (RO_MASK[gi]) begin : g_ro
      assign reg_value[gi]        = hw_status[gi*DW +: DW];
      assign reg_q[gi*DW +: DW]   = '0;
    end else begin : g_rw
      logic [DW-1:0] value_reg;
      logic          status_unused;

      always_ff @(posedge clk) begin
        if (!s00_axi_aresetn) begin
          value_reg <= '0;
        end else if (wr_en && wr_hit[gi]) begin
          for (int k = 0; k < SW; k++) begin
            if (commit_strb[k]) begin
              value_reg[k*8 +: 8] <= commit_data[k*8 +: 8];
            end
          end
        end
      end

      assign reg_value[gi]      = value_reg;
      assign reg_q[gi*DW +: DW] = value_reg;
      assign status_unused      = ^hw_status[gi*DW +: DW];
    end
  end

  // Pulses even for wstrb == 0, as long as the write was accepted as OKAY.
  always_ff @(posedge clk) begin
    if (!s00_axi_aresetn) begin
      wr_pulse_reg <= '0;
    end else begin
      wr_pulse_reg <= wr_en ? wr_hit : '0;
    end
  end

  assign wr_pulse = wr_pulse_reg;

  // Read path. The value is sampled on the handshake edge, so a write
  // committing on that same edge is not yet visible to the read.
  assign rd_idx          = s00_axi_araddr[AW-1:LSB];
  assign s00_axi_arready = rd_active_reg && !rvalid_reg;
  assign ar_hs           = s00_axi_arvalid && s00_axi_arready;

  always_comb begin
    rd_in_range = 1'b0;
    rd_value    = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_in_range = 1'b1;
        rd_value    = reg_value[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!s00_axi_aresetn) begin
      rd_active_reg <= 1'b0;
      rvalid_reg    <= 1'b0;
      rdata_reg     <= '0;
      rresp_reg     <= RESP_OKAY;
    end else begin
      rd_active_reg <= 1'b1;
      if (ar_hs) begin
        rvalid_reg <= 1'b1;
        rdata_reg  <= rd_in_range ? rd_value : '0;
        rresp_reg  <= rd_in_range ? RESP_OKAY : RESP_DECERR;
      end else if (rvalid_reg && s00_axi_rready) begin
        rvalid_reg <= 1'b0;
      end
    end
  end

  assign s00_axi_rvalid = rvalid_reg;
  assign s00_axi_rdata  = rdata_reg;
  assign s00_axi_rresp  = rresp_reg;

  assign unused = ^{s00_axi_awprot, s00_axi_arprot,
                    s00_axi_araddr[LSB-1:0], commit_addr[LSB-1:0]};

endmodule

// File: tb/tb_axil_regbank.sv
module tb_axil_regbank;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int NR = 8;
  localparam int SW = DW / 8;

  logic                 clk = 1'b0;
  logic                 aresetn;
  logic [AW-1:0]        awaddr;
  logic [2:0]           awprot;
  logic                 awvalid;
  logic                 awready;
  logic [DW-1:0]        wdata;
  logic [SW-1:0]        wstrb;
  logic                 wvalid;
  logic                 wready;
  logic [1:0]           bresp;
  logic                 bvalid;
  logic                 bready;
  logic [AW-1:0]        araddr;
  logic [2:0]           arprot;
  logic                 arvalid;
  logic                 arready;
  logic [DW-1:0]        rdata;
  logic [1:0]           rresp;
  logic                 rvalid;
  logic                 rready;
  logic [NR*DW-1:0]     reg_q;
  logic [NR-1:0]        wr_pulse;
  logic [NR*DW-1:0]     hw_status;

  always #5 clk = ~clk;

  axil_regbank #(
    .C_S_AXI_DATA_WIDTH (DW),
    .C_S_AXI_ADDR_WIDTH (AW),
    .NUM_REGS           (NR),
    .RO_MASK            (8'hF0)
  ) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (aresetn),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awprot  (awprot),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arprot  (arprot),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .reg_q           (reg_q),
    .wr_pulse        (wr_pulse),
    .hw_status       (hw_status)
  );

  // Reference model: register file as plain words, read-only set as a mask.
  logic [DW-1:0] model [NR];
  logic [NR-1:0] ro_bits = 8'hF0;

  typedef struct {
    logic [1:0]       resp;
    logic [NR-1:0]    pulse;
    logic [NR*DW-1:0] regq;
  } b_exp_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    resp;
  } r_exp_t;

  b_exp_t b_q[$];
  r_exp_t r_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  function automatic logic [NR*DW-1:0] model_flat();
    logic [NR*DW-1:0] f;
    f = '0;
    for (int i = 0; i < NR; i++) begin
      if (!ro_bits[i]) f[i*DW +: DW] = model[i];
    end
    return f;
  endfunction

  // Monitor: pops expectations whenever the DUT presents a response.
  logic bvalid_prev = 1'b0;
  always @(negedge clk) begin : monitor
    b_exp_t be;
    r_exp_t re;
    if (bvalid && !bvalid_prev) begin
      if (b_q.size() == 0) begin
        fail("unexpected_bvalid");
      end else begin
        check("wr_pulse", 256'(wr_pulse), 256'(b_q[0].pulse));
        check("reg_q", 256'(reg_q), 256'(b_q[0].regq));
      end
    end else begin
      check("wr_pulse_idle", 256'(wr_pulse), 256'(0));
    end
    if (bvalid && bready) begin
      if (b_q.size() == 0) begin
        fail("unexpected_b");
      end else begin
        be = b_q.pop_front();
        check("bresp", 256'(bresp), 256'(be.resp));
        $display("B  resp=%0d exp=%0d", bresp, be.resp);
      end
    end
    if (rvalid && rready) begin
      if (r_q.size() == 0) begin
        fail("unexpected_r");
      end else begin
        re = r_q.pop_front();
        check("rdata", 256'(rdata), 256'(re.data));
        check("rresp", 256'(rresp), 256'(re.resp));
        $display("R  data=%08h resp=%0d exp=%08h/%0d", rdata, rresp, re.data, re.resp);
      end
    end
    bvalid_prev <= bvalid;
  end

  // All driver tasks start and end just after a rising edge.
  task automatic send_aw(input logic [AW-1:0] a, input int dly);
    bit ok;
    repeat (dly) begin @(posedge clk); #1; end
    awaddr = a;
    awvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (awready) begin ok = 1'b1; break; end
    end
    if (!ok) fail("aw_handshake");
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [DW-1:0] d, input logic [SW-1:0] s, input int dly);
    bit ok;
    repeat (dly) begin @(posedge clk); #1; end
    wdata = d;
    wstrb = s;
    wvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (wready) begin ok = 1'b1; break; end
    end
    if (!ok) fail("w_handshake");
    @(posedge clk); #1;
    wvalid = 1'b0;
  endtask

  // Called at a falling edge; returns just after the B handshake edge.
  task automatic finish_b();
    for (int i = 0; i < 50; i++) begin
      if (bvalid && bready) begin
        @(posedge clk); #1;
        return;
      end
      @(negedge clk);
    end
    fail("b_handshake");
    @(posedge clk); #1;
  endtask

  // With wait_b = 0 the task returns at the falling edge after commit.
  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [SW-1:0] strb, input int da, input int dw,
                          input bit wait_b);
    b_exp_t e;
    int idx;
    idx = int'(addr >> 2);
    e.pulse = '0;
    if (idx >= NR) begin
      e.resp = 2'b11;
    end else if (ro_bits[idx]) begin
      e.resp = 2'b10;
    end else begin
      for (int k = 0; k < SW; k++) begin
        if (strb[k]) model[idx][k*8 +: 8] = data[k*8 +: 8];
      end
      e.resp = 2'b00;
      e.pulse[idx] = 1'b1;
    end
    e.regq = model_flat();
    b_q.push_back(e);
    $display("WR addr=%02h data=%08h strb=%b aw_dly=%0d w_dly=%0d", addr, data, strb, da, dw);
    fork
      send_aw(addr, da);
      send_w(data, strb, dw);
    join
    @(negedge clk);
    check("b_latency", 256'(bvalid), 256'(1));
    if (wait_b) finish_b();
  endtask

  task automatic do_read(input logic [AW-1:0] addr);
    r_exp_t e;
    int idx;
    bit ok;
    idx = int'(addr >> 2);
    if (idx >= NR) begin
      e.data = '0;
      e.resp = 2'b11;
    end else if (ro_bits[idx]) begin
      e.data = hw_status[idx*DW +: DW];
      e.resp = 2'b00;
    end else begin
      e.data = model[idx];
      e.resp = 2'b00;
    end
    r_q.push_back(e);
    $display("RD addr=%02h", addr);
    araddr = addr;
    arvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (arready) begin ok = 1'b1; break; end
    end
    if (!ok) fail("ar_handshake");
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    check("r_latency", 256'(rvalid), 256'(1));
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (rvalid && rready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) fail("r_handshake");
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_awready"}, 256'(awready), 256'(0));
    check({tag, "_wready"},  256'(wready),  256'(0));
    check({tag, "_arready"}, 256'(arready), 256'(0));
    check({tag, "_bvalid"},  256'(bvalid),  256'(0));
    check({tag, "_rvalid"},  256'(rvalid),  256'(0));
    check({tag, "_bresp"},   256'(bresp),   256'(0));
    check({tag, "_rresp"},   256'(rresp),   256'(0));
    check({tag, "_rdata"},   256'(rdata),   256'(0));
    check({tag, "_reg_q"},   256'(reg_q),   256'(0));
    check({tag, "_wr_pulse"}, 256'(wr_pulse), 256'(0));
  endtask

  initial begin
    aresetn = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;
    hw_status = '0;
    for (int i = 0; i < NR; i++) model[i] = '0;

    // Reset state, including the cycle where release is not yet sampled.
    repeat (3) @(posedge clk);
    #1 aresetn = 1'b1;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    @(negedge clk);
    check("ready_after_reset_aw", 256'(awready), 256'(1));
    check("ready_after_reset_w",  256'(wready),  256'(1));
    check("ready_after_reset_ar", 256'(arready), 256'(1));
    @(posedge clk); #1;

    // Basic writes and readback of four RW registers.
    for (int i = 0; i < 4; i++) do_write(AW'(i * 4), DW'(i + 1), 4'hF, 0, 0, 1);
    for (int i = 0; i < 4; i++) do_read(AW'(i * 4));

    // W leads AW by 3 cycles, then AW leads W by 3 cycles.
    do_write(6'h08, 32'hA5A5_0001, 4'hF, 3, 0, 1);
    do_write(6'h0C, 32'h5A5A_0002, 4'hF, 0, 3, 1);
    do_read(6'h08);
    do_read(6'h0C);

    // Byte strobes.
    do_write(6'h04, 32'hFFFF_FFFF, 4'hF, 0, 0, 1);
    do_write(6'h04, 32'h1234_5678, 4'b0101, 1, 0, 1);
    do_read(6'h04);

    // Read-only and out-of-range accesses; wstrb=0 still pulses.
    hw_status[4*DW +: DW] = 32'hCAFE_0001;
    do_read(6'h10);
    do_write(6'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 1);
    do_read(6'h10);
    do_read(6'h20);
    do_write(6'h24, 32'h0BAD_0BAD, 4'hF, 0, 0, 1);
    do_write(6'h08, 32'h0000_0000, 4'h0, 0, 0, 1);

    // B stalled for 10 cycles; a read still completes meanwhile.
    bready = 1'b0;
    do_write(6'h00, 32'h0F0F_1234, 4'hF, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      awvalid = 1'b1;
      wvalid = 1'b1;
      @(negedge clk);
      check("stall_awready", 256'(awready), 256'(0));
      check("stall_wready",  256'(wready),  256'(0));
      check("stall_bvalid",  256'(bvalid),  256'(1));
      check("stall_bresp",   256'(bresp),   256'(0));
    end
    @(posedge clk); #1;
    awvalid = 1'b0;
    wvalid = 1'b0;
    do_read(6'h04);
    bready = 1'b1;
    @(negedge clk);
    finish_b();

    // Random traffic.
    for (int n = 0; n < 150; n++) begin
      logic [AW-1:0] a;
      for (int i = 0; i < NR; i++) hw_status[i*DW +: DW] = $urandom;
      a = AW'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        do_read(a);
      end else begin
        do_write(a, DW'($urandom), SW'($urandom), $urandom_range(0, 3),
                 $urandom_range(0, 3), 1);
      end
    end

    // Reset with AW held and W not yet presented: no B may follow.
    send_aw(6'h04, 0);
    aresetn = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_all_zero("midreset");
    @(posedge clk); #1;
    aresetn = 1'b1;
    for (int i = 0; i < NR; i++) model[i] = '0;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    check("midreset_no_b", 256'(bvalid), 256'(0));
    do_write(6'h04, 32'h7777_8888, 4'hF, 0, 2, 1);
    do_read(6'h04);
    do_read(6'h00);

    repeat (5) @(posedge clk);
    check("queues_empty", 256'(b_q.size() + r_q.size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
